// File: rtl/tlb_array.sv
// Fully-associative TLB fed by the page-structure walker. Lookups are purely
// combinational; writes, invalidations and lookup counting happen on the clock.
module tlb_array #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [51:0] pgnoin,
    input  logic        tlbwr,
    input  logic [63:0] writeentry,
    input  logic        flushall,
    input  logic        invlpg,
    input  logic [51:0] invvpn,
    input  logic        lookupen,
    output logic        hit,
    output logic [51:0] ppnout,
    output logic [1:0]  flagsout,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
);
    localparam int IDXW = $clog2(ENTRIES);

    // Per-entry state: valid bits are reset, payload arrays are not.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [51:0]        tag_q   [ENTRIES];
    logic [51:0]        ppn_q   [ENTRIES];
    logic [1:0]         flags_q [ENTRIES];
    logic [IDXW-1:0]    rr_q, rr_d;
    logic [31:0]        hitcnt_q, hitcnt_d;
    logic [31:0]        misscnt_q, misscnt_d;

    logic [ENTRIES-1:0] match;
    logic [ENTRIES-1:0] inv_match;
    logic [IDXW-1:0]    hit_idx;
    logic [IDXW-1:0]    free_idx;
    logic [IDXW-1:0]    wr_idx;
    logic               have_free;
    logic               use_rr;
    logic               wr_en;

    // Bits [11:3] of the leaf carry nothing this array stores.
    logic unused_entry_bits;
    assign unused_entry_bits = ^writeentry[11:3];

    // Tag compare and AND-OR mux of the (at most one) matching entry.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        match    = '0;
        ppnout   = '0;
        flagsout = '0;
        hit_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == pgnoin);
            if (match[i]) begin
                ppnout   = ppnout | ppn_q[i];
                flagsout = flagsout | flags_q[i];
                hit_idx  = hit_idx | IDXW'(i);
            end
        end
    end

    assign hit = |match;

    // Write-target choice: in-place hit, else lowest invalid slot, else round-robin victim.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDXW'(i);
            end
        end
        use_rr = !hit && !have_free;
        if (hit) begin
            wr_idx = hit_idx;
        end else if (have_free) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = rr_q;
        end
    end

    // A present leaf is captured unless a flush, or an invalidation of the same VPN, cancels it.
    assign wr_en = tlbwr && writeentry[0] && !flushall && !(invlpg && (invvpn == pgnoin));

    // Next valid bits, replacement pointer and saturating lookup counters.
    always_comb begin
        valid_d   = valid_q;
        rr_d      = rr_q;
        hitcnt_d  = hitcnt_q;
        misscnt_d = misscnt_q;
        inv_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            inv_match[i] = valid_q[i] && (tag_q[i] == invvpn);
        end
        if (flushall) begin
            valid_d = '0;
        end else begin
            if (invlpg) begin
                valid_d = valid_d & ~inv_match;
            end
            if (wr_en) begin
                valid_d[wr_idx] = 1'b1;
                if (use_rr) begin
                    rr_d = rr_q + IDXW'(1);
                end
            end
        end
        if (lookupen) begin
            if (hit) begin
                if (hitcnt_q != '1) hitcnt_d = hitcnt_q + 32'd1;
            end else begin
                if (misscnt_q != '1) misscnt_d = misscnt_q + 32'd1;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            valid_q   <= '0;
            rr_q      <= '0;
            hitcnt_q  <= '0;
            misscnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            hitcnt_q  <= hitcnt_d;
            misscnt_q <= misscnt_d;
        end
    end

    // Entry payload storage; only the target of an accepted write changes.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays carry no reset; an entry is only observable once its valid bit is set.
        if (wr_en) begin
            tag_q[wr_idx]   <= pgnoin;
            ppn_q[wr_idx]   <= writeentry[63:12];
            flags_q[wr_idx] <= writeentry[2:1];
        end
    end

    assign hitcnt  = hitcnt_q;
    assign misscnt = misscnt_q;

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array (4-entry instance) with a slot-level reference model.
module tb_tlb_array;
    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [51:0] pgnoin;
    logic        tlbwr;
    logic [63:0] writeentry;
    logic        flushall;
    logic        invlpg;
    logic [51:0] invvpn;
    logic        lookupen;
    logic        hit;
    logic [51:0] ppnout;
    logic [1:0]  flagsout;
    logic [31:0] hitcnt;
    logic [31:0] misscnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 0;
    bit preload_miss = 0;

    tlb_array #(.ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .pgnoin(pgnoin), .tlbwr(tlbwr),
        .writeentry(writeentry), .flushall(flushall), .invlpg(invlpg),
        .invvpn(invvpn), .lookupen(lookupen), .hit(hit), .ppnout(ppnout),
        .flagsout(flagsout), .hitcnt(hitcnt), .misscnt(misscnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slot contents, victim pointer and counters.
    bit          m_v   [N];
    logic [51:0] m_tag [N];
    logic [51:0] m_ppn [N];
    logic [1:0]  m_fl  [N];
    int          m_rr;
    logic [31:0] m_hc;
    logic [31:0] m_mc;

    function automatic int m_find(input logic [51:0] vpn);
        for (int i = 0; i < N; i++) if (m_v[i] && m_tag[i] == vpn) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int f;
        int t;
        int k;
        if (reset) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_rr = 0;
            m_hc = 0;
            m_mc = 0;
        end else begin
            f = m_find(pgnoin);
            if (lookupen) begin
                if (f >= 0) begin
                    if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
                end else if (m_mc != 32'hFFFF_FFFF) begin
                    m_mc = m_mc + 1;
                end
            end
            if (preload_miss) m_mc = 32'hFFFF_FFFE;
            if (flushall) begin
                for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            end else begin
                t = -1;
                if (tlbwr && writeentry[0] && !(invlpg && invvpn == pgnoin)) begin
                    if (f >= 0) t = f;
                    else begin
                        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) t = i;
                        if (t < 0) begin
                            t = m_rr;
                            m_rr = (m_rr + 1) % N;
                        end
                    end
                end
                if (invlpg) begin
                    k = m_find(invvpn);
                    if (k >= 0) m_v[k] = 1'b0;
                end
                if (t >= 0) begin
                    m_v[t]   = 1'b1;
                    m_tag[t] = pgnoin;
                    m_ppn[t] = writeentry[63:12];
                    m_fl[t]  = writeentry[2:1];
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        int k;
        if (cmp_en && !reset) begin
            k = m_find(pgnoin);
            check("cmp_hit", 64'(hit), 64'(k >= 0));
            check("cmp_ppn", 64'(ppnout), (k >= 0) ? 64'(m_ppn[k]) : 64'd0);
            check("cmp_flags", 64'(flagsout), (k >= 0) ? 64'(m_fl[k]) : 64'd0);
            check("cmp_hitcnt", 64'(hitcnt), 64'(m_hc));
            check("cmp_misscnt", 64'(misscnt), 64'(m_mc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tlbwr = 1'b0;
        flushall = 1'b0;
        invlpg = 1'b0;
        preload_miss = 1'b0;
    endtask

    task automatic wr_raw(input logic [51:0] vpn, input logic [63:0] entry);
        pgnoin = vpn;
        writeentry = entry;
        tlbwr = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [51:0] vpn, input logic [51:0] ppn, input logic [1:0] fl, input bit present);
        wr_raw(vpn, {ppn, 9'd0, fl, present});
    endtask

    task automatic look(input logic [51:0] vpn);
        pgnoin = vpn;
        @(negedge clk);
        #1;
    endtask

    task automatic exp_hit(input logic [51:0] vpn, input logic [51:0] ppn, input logic [1:0] fl);
        look(vpn);
        check("lit_hit", 64'(hit), 64'd1);
        check("lit_ppn", 64'(ppnout), 64'(ppn));
        check("lit_flags", 64'(flagsout), 64'(fl));
    endtask

    task automatic exp_miss(input logic [51:0] vpn);
        look(vpn);
        check("lit_miss", 64'(hit), 64'd0);
        check("lit_miss_ppn", 64'(ppnout), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pgnoin = '0;
        tlbwr = 1'b0;
        writeentry = '0;
        flushall = 1'b0;
        invlpg = 1'b0;
        invvpn = '0;
        lookupen = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_ppn", 64'(ppnout), 64'd0);
        check("rst_hitcnt", 64'(hitcnt), 64'd0);
        check("rst_misscnt", 64'(misscnt), 64'd0);

        // Three counted misses on an empty array.
        pgnoin = 52'h1;
        lookupen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lookupen = 1'b0;
        @(negedge clk);
        #1;
        check("miss3_misscnt", 64'(misscnt), 64'd3);
        check("miss3_hitcnt", 64'(hitcnt), 64'd0);
        lookupen = 1'b1;

        // Single write and neighbour lookup.
        wr_raw(52'hABC, 64'h0000_0123_4567_8007);
        exp_hit(52'hABC, 52'h0_0123_4567_8, 2'b11);
        exp_miss(52'hABD);

        // Fill, then round-robin replacement.
        flushall = 1'b1;
        tick();
        for (int v = 1; v <= 4; v++) wr(52'(v), 52'h100 + 52'(v), 2'(v), 1'b1);
        wr(52'd5, 52'h105, 2'd1, 1'b1);
        exp_miss(52'd1);
        exp_hit(52'd2, 52'h102, 2'd2);
        wr(52'd6, 52'h106, 2'd2, 1'b1);
        exp_miss(52'd2);
        for (int v = 3; v <= 6; v++) exp_hit(52'(v), 52'h100 + 52'(v), 2'(v));

        // In-place rewrite leaves the pointer alone; the next victim is VPN 3's slot.
        wr(52'd3, 52'h77, 2'b01, 1'b1);
        exp_hit(52'd3, 52'h77, 2'b01);
        for (int v = 4; v <= 6; v++) exp_hit(52'(v), 52'h100 + 52'(v), 2'(v));
        wr(52'd7, 52'h107, 2'd3, 1'b1);
        exp_miss(52'd3);
        exp_hit(52'd4, 52'h104, 2'd0);

        // Not-present leaf is ignored.
        wr(52'd9, 52'h109, 2'd1, 1'b0);
        exp_miss(52'd9);
        exp_hit(52'd7, 52'h107, 2'd3);

        // invlpg and tlbwr on the same VPN: entry ends invalid.
        invlpg = 1'b1;
        invvpn = 52'd5;
        wr(52'd5, 52'h205, 2'd0, 1'b1);
        exp_miss(52'd5);

        // invlpg of another VPN with a write: both take effect, write lands in the free slot.
        invlpg = 1'b1;
        invvpn = 52'd6;
        wr(52'hA, 52'h10A, 2'd2, 1'b1);
        exp_hit(52'hA, 52'h10A, 2'd2);
        exp_miss(52'd6);
        exp_hit(52'd7, 52'h107, 2'd3);
        exp_hit(52'd4, 52'h104, 2'd0);

        // flushall beats a same-edge write.
        flushall = 1'b1;
        wr(52'd8, 52'h108, 2'd1, 1'b1);
        exp_miss(52'd8);
        exp_miss(52'hA);
        exp_miss(52'd7);
        exp_miss(52'd4);

        // Miss counter saturation from a preloaded value.
        lookupen = 1'b0;
        preload_miss = 1'b1;
        @(posedge clk);
        #1;
        force dut.misscnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.misscnt_q;
        preload_miss = 1'b0;
        @(negedge clk);
        #1;
        check("preload_misscnt", 64'(misscnt), 64'hFFFF_FFFE);
        pgnoin = 52'h999;
        lookupen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lookupen = 1'b0;
        @(negedge clk);
        #1;
        check("sat_misscnt", 64'(misscnt), 64'hFFFF_FFFF);

        // Asynchronous reset between edges.
        lookupen = 1'b1;
        wr(52'h20, 52'h120, 2'd1, 1'b1);
        exp_hit(52'h20, 52'h120, 2'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_hit", 64'(hit), 64'd0);
        check("arst_ppn", 64'(ppnout), 64'd0);
        check("arst_hitcnt", 64'(hitcnt), 64'd0);
        check("arst_misscnt", 64'(misscnt), 64'd0);
        #1;
        reset = 1'b0;
        lookupen = 1'b0;
        exp_miss(52'h20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
